torgb_rgb_pack: RTL

- Downstream stage of the torgb datapath. Consumes the signed fixed-point partial products from the 32s x 34ns multipliers: one luma term, and chroma terms per channel.
- Per channel: sums the terms, rounds, drops the fractional bits and saturates to 8 bits.
- Packs R/G/B into a 24-bit video-stream beat with valid/ready handshake.
- Generates start-of-frame (user) and end-of-line (last) flags from internal column/row counters.

---
 rtl/torgb_pkg.sv | 21 ++
 rtl/torgb_round_clamp.sv | 31 +++
 rtl/torgb_rgb_pack.sv | 112 +++++++++++
 3 files changed

// File: rtl/torgb_pkg.sv
// Shared constants and types for the torgb output datapath.
//   PROD_W  : width of each signed multiplier product
//   FRAC    : fractional bits carried in the products
//   LANE_*  : byte-lane offsets of R/G/B inside the 24-bit stream word
//   pixel_t : one packed RGB pixel, R in the most significant byte
package torgb_pkg;

  localparam int PROD_W = 65;
  localparam int FRAC   = 32;

  localparam int LANE_R = 16;
  localparam int LANE_G = 8;
  localparam int LANE_B = 0;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

endpackage

// File: rtl/torgb_round_clamp.sv
// Round-half-up, drop fractional bits and saturate a signed fixed-point
// sum to an unsigned 8-bit pixel component. Purely combinational.
//   i_sum : signed sum, IN_W bits, FRAC fractional bits
//   o_pix : 0 if rounded value < 0, 255 if > 255, else rounded value
module torgb_round_clamp #(
  parameter int IN_W = 67,
  parameter int FRAC = 32
) (
  input  logic signed [IN_W-1:0] i_sum,
  output logic        [7:0]      o_pix
);

  // One extra bit so adding the half-LSB can never wrap.
  localparam logic signed [IN_W:0] HALF = (IN_W+1)'(1) <<< (FRAC-1);

  logic signed [IN_W:0] w_rnd;
  logic signed [IN_W:0] w_t;

  assign w_rnd = {i_sum[IN_W-1], i_sum} + HALF;
  assign w_t   = w_rnd >>> FRAC;

  always_comb begin
    o_pix = w_t[7:0];
    if (w_t[IN_W]) begin
      o_pix = '0;
    end else if (w_t > (IN_W+1)'(255)) begin
      o_pix = '1;
    end
  end

endmodule

// File: rtl/torgb_rgb_pack.sv
// torgb output stage: sums luma/chroma products per channel, rounds and
// clamps to 8 bits, and emits a 24-bit video-stream beat with sof/eol flags.
//   ap_clk, ap_rst_n            : clock, async active-low reset
//   in_valid / in_ready          : input handshake
//   y/rv/gu/gv/bu_term           : signed PROD_W-bit products (FRAC frac bits)
//   out_valid / out_ready        : output handshake
//   out_data                     : {R, G, B}
//   out_user / out_last          : first pixel of frame / last pixel of line
module torgb_rgb_pack #(
  parameter int PROD_W = torgb_pkg::PROD_W,
  parameter int FRAC   = torgb_pkg::FRAC,
  parameter int IMG_W  = 1920,
  parameter int IMG_H  = 1080
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [PROD_W-1:0] y_term,
  input  logic signed [PROD_W-1:0] rv_term,
  input  logic signed [PROD_W-1:0] gu_term,
  input  logic signed [PROD_W-1:0] gv_term,
  input  logic signed [PROD_W-1:0] bu_term,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [23:0]              out_data,
  output logic                     out_user,
  output logic                     out_last
);

  import torgb_pkg::pixel_t;
  import torgb_pkg::LANE_R;
  import torgb_pkg::LANE_G;
  import torgb_pkg::LANE_B;

  localparam int SW = PROD_W + 2;
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  function automatic logic signed [SW-1:0] sext(input logic signed [PROD_W-1:0] v);
    return {{2{v[PROD_W-1]}}, v};
  endfunction

  logic                 w_advance;
  logic                 w_out_hs;
  logic signed [SW-1:0] w_sr, w_sg, w_sb;
  logic signed [SW-1:0] r_sr, r_sg, r_sb;
  logic                 r_v1;
  pixel_t               w_pix;
  pixel_t               r_pix;
  logic                 r_out_valid;
  logic [CW-1:0]        r_col;
  logic [RW-1:0]        r_row;

  // The whole pipe moves as one; the output register is the only place
  // that can be blocked, so in_ready never depends on in_valid.
  assign w_advance = ~r_out_valid | out_ready;
  assign w_out_hs  = r_out_valid & out_ready;
  assign in_ready  = w_advance;

  assign w_sr = sext(y_term) + sext(rv_term);
  assign w_sg = sext(y_term) + sext(gu_term) + sext(gv_term);
  assign w_sb = sext(y_term) + sext(bu_term);

  torgb_round_clamp #(.IN_W(SW), .FRAC(FRAC)) u_rc_r (.i_sum(r_sr), .o_pix(w_pix.r));
  torgb_round_clamp #(.IN_W(SW), .FRAC(FRAC)) u_rc_g (.i_sum(r_sg), .o_pix(w_pix.g));
  torgb_round_clamp #(.IN_W(SW), .FRAC(FRAC)) u_rc_b (.i_sum(r_sb), .o_pix(w_pix.b));

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_sr        <= '0;
      r_sg        <= '0;
      r_sb        <= '0;
      r_v1        <= 1'b0;
      r_pix       <= '0;
      r_out_valid <= 1'b0;
    end else if (w_advance) begin
      r_sr        <= w_sr;
      r_sg        <= w_sg;
      r_sb        <= w_sb;
      r_v1        <= in_valid;
      r_pix       <= w_pix;
      r_out_valid <= r_v1;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_out_hs) begin
      if (r_col == CW'(IMG_W-1)) begin
        r_col <= '0;
        r_row <= (r_row == RW'(IMG_H-1)) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  always_comb begin
    out_data              = '0;
    out_data[LANE_R +: 8] = r_pix.r;
    out_data[LANE_G +: 8] = r_pix.g;
    out_data[LANE_B +: 8] = r_pix.b;
  end

  assign out_valid = r_out_valid;
  assign out_user  = (r_col == '0) && (r_row == '0);
  assign out_last  = (r_col == CW'(IMG_W-1));

endmodule
